// File: rtl/skin_mask_pkg.sv
// Shared types and width helpers for the skin-mask frame classifier.
package skin_mask_pkg;

    // Frame controller states
    typedef enum logic [2:0] {
        IDLE,
        STREAM,
        DIV_X,
        DIV_Y,
        REPORT
    } state_t;

    // Power-on chroma window suggestions for a typical skin tone
    localparam int U_LO_DEF = 26;
    localparam int U_HI_DEF = 74;
    localparam int V_LO_DEF = 0;
    localparam int V_HI_DEF = 255;

    // Bits needed to index n positions (at least one bit)
    function automatic int coordWidth(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

    // Bits needed to hold a pixel count from 0 to w*h inclusive
    function automatic int countWidth(input int w, input int h);
        return $clog2(w * h + 1);
    endfunction

    // Bits needed for a coordinate sum over every pixel of the frame
    function automatic int sumWidth(input int w, input int h);
        int cw;
        cw = (coordWidth(w) > coordWidth(h)) ? coordWidth(w) : coordWidth(h);
        return cw + countWidth(w, h);
    endfunction

endpackage

// File: rtl/skin_mask_frame_if.sv
// Pixel-in / mask-out stream bundle between a pixel source, the classifier and its sink.
interface skin_mask_frame_if #(
    parameter int COLOR_DEPTH = 8
);
    logic                   in_valid;
    logic                   in_ready;
    logic [COLOR_DEPTH-1:0] in_r;
    logic [COLOR_DEPTH-1:0] in_g;
    logic [COLOR_DEPTH-1:0] in_b;
    logic                   out_valid;
    logic                   out_ready;
    logic [COLOR_DEPTH-1:0] out_pixel;
    logic                   out_last;

    // Environment side: supplies pixels and drains the mask
    modport master (
        output in_valid, in_r, in_g, in_b, out_ready,
        input  in_ready, out_valid, out_pixel, out_last
    );

    // Classifier side: consumes pixels and produces the mask
    modport slave (
        input  in_valid, in_r, in_g, in_b, out_ready,
        output in_ready, out_valid, out_pixel, out_last
    );
endinterface

// File: rtl/skin_mask_frame_seq_divider.sv
// Restoring unsigned divider, one quotient bit per cycle; divisor is never zero.
module seq_divider #(
    parameter int N = 16,
    parameter int D = 8
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         start,
    input  logic [N-1:0] dividend,
    input  logic [D-1:0] divisor,
    output logic         busy,
    output logic         done,
    output logic [N-1:0] quotient
);
    localparam int CNTW = $clog2(N + 1);

    logic [N-1:0]    work_q, work_d;
    logic [D-1:0]    rem_q, rem_d;
    logic [D-1:0]    div_q, div_d;
    logic [CNTW-1:0] bitCnt_q, bitCnt_d;
    logic            busy_q, busy_d;
    logic            done_q, done_d;
    logic [D:0]      trial;
    logic [D-1:0]    trialDiff;

    // One restoring step: shift in the next dividend bit and subtract when it fits
    always_comb begin
        trial     = {rem_q, work_q[N-1]};
        trialDiff = trial[D-1:0] - div_q;
        work_d    = work_q;
        rem_d     = rem_q;
        div_d     = div_q;
        bitCnt_d  = bitCnt_q;
        busy_d    = busy_q;
        done_d    = 1'b0;
        if (start && !busy_q) begin
            work_d   = dividend;
            rem_d    = '0;
            div_d    = divisor;
            bitCnt_d = CNTW'(N);
            busy_d   = 1'b1;
        end else if (busy_q) begin
            if (trial >= {1'b0, div_q}) begin
                rem_d  = trialDiff;
                work_d = {work_q[N-2:0], 1'b1};
            end else begin
                rem_d  = trial[D-1:0];
                work_d = {work_q[N-2:0], 1'b0};
            end
            bitCnt_d = bitCnt_q - CNTW'(1);
            if (bitCnt_q == CNTW'(1)) begin
                busy_d = 1'b0;
                done_d = 1'b1;
            end
        end
    end

    // Divider state registers
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            work_q   <= '0;
            rem_q    <= '0;
            div_q    <= '0;
            bitCnt_q <= '0;
            busy_q   <= 1'b0;
            done_q   <= 1'b0;
        end else begin
            work_q   <= work_d;
            rem_q    <= rem_d;
            div_q    <= div_d;
            bitCnt_q <= bitCnt_d;
            busy_q   <= busy_d;
            done_q   <= done_d;
        end
    end

    assign busy     = busy_q;
    assign done     = done_q;
    assign quotient = work_q;

endmodule

// File: rtl/skin_mask_frame.sv
// Streams one RGB frame, emits a 0/all-ones skin mask and reports bbox, count and centroid.
module skin_mask_frame
    import skin_mask_pkg::*;
#(
    parameter int WIDTH       = 256,
    parameter int HEIGHT      = 256,
    parameter int COLOR_DEPTH = 8
) (
    input  logic                                 clk,
    input  logic                                 rst_n,
    input  logic                                 start,
    input  logic [COLOR_DEPTH-1:0]               u_lo,
    input  logic [COLOR_DEPTH-1:0]               u_hi,
    input  logic [COLOR_DEPTH-1:0]               v_lo,
    input  logic [COLOR_DEPTH-1:0]               v_hi,
    skin_mask_frame_if.slave                     pix,
    output logic                                 busy,
    output logic                                 result_valid,
    output logic                                 found,
    output logic [countWidth(WIDTH, HEIGHT)-1:0] count,
    output logic [coordWidth(WIDTH)-1:0]         cx,
    output logic [coordWidth(HEIGHT)-1:0]        cy,
    output logic [coordWidth(WIDTH)-1:0]         min_x,
    output logic [coordWidth(WIDTH)-1:0]         max_x,
    output logic [coordWidth(HEIGHT)-1:0]        min_y,
    output logic [coordWidth(HEIGHT)-1:0]        max_y
);
    localparam int XW = coordWidth(WIDTH);
    localparam int YW = coordWidth(HEIGHT);
    localparam int CW = countWidth(WIDTH, HEIGHT);
    localparam int SW = sumWidth(WIDTH, HEIGHT);
    localparam logic [XW-1:0] X_LAST  = XW'(WIDTH - 1);
    localparam logic [YW-1:0] Y_LAST  = YW'(HEIGHT - 1);
    localparam logic [SW-1:0] X_LIMIT = SW'(WIDTH - 1);
    localparam logic [SW-1:0] Y_LIMIT = SW'(HEIGHT - 1);

    state_t state_q, state_d;

    logic [XW-1:0] posX_q, posX_d;
    logic [YW-1:0] posY_q, posY_d;
    logic [SW-1:0] sumX_q, sumX_d;
    logic [SW-1:0] sumY_q, sumY_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic [XW-1:0] minX_q, minX_d, maxX_q, maxX_d;
    logic [YW-1:0] minY_q, minY_d, maxY_q, maxY_d;

    logic [COLOR_DEPTH-1:0] uLo_q, uLo_d, uHi_q, uHi_d;
    logic [COLOR_DEPTH-1:0] vLo_q, vLo_d, vHi_q, vHi_d;

    logic                   outValid_q, outValid_d;
    logic [COLOR_DEPTH-1:0] outPixel_q, outPixel_d;
    logic                   outLast_q, outLast_d;

    logic          divPending_q, divPending_d;
    logic [XW-1:0] cxInt_q, cxInt_d;
    logic [YW-1:0] cyInt_q, cyInt_d;

    logic          resValid_q, resValid_d;
    logic          resFound_q, resFound_d;
    logic [CW-1:0] resCount_q, resCount_d;
    logic [XW-1:0] resCx_q, resCx_d, resMinX_q, resMinX_d, resMaxX_q, resMaxX_d;
    logic [YW-1:0] resCy_q, resCy_d, resMinY_q, resMinY_d, resMaxY_q, resMaxY_d;

    logic [COLOR_DEPTH-1:0] uVal, vVal;
    logic                   isSkin;
    logic                   inReady;
    logic                   accept;
    logic                   lastPix;
    logic                   divStart, divBusy, divDone;
    logic [SW-1:0]          divDividend, divQuotient;
    logic [XW-1:0]          cxQuot;
    logic [YW-1:0]          cyQuot;

    // Saturating chroma differences and the window test against the latched thresholds
    always_comb begin
        uVal = '0;
        vVal = '0;
        if (pix.in_r > pix.in_g) uVal = pix.in_r - pix.in_g;
        if (pix.in_b > pix.in_g) vVal = pix.in_b - pix.in_g;
        isSkin = (uLo_q < uVal) && (uVal < uHi_q) && (vLo_q <= vVal) && (vVal <= vHi_q);
    end

    assign inReady     = (state_q == STREAM) && (!outValid_q || pix.out_ready);
    assign accept      = pix.in_valid && inReady;
    assign lastPix     = (posX_q == X_LAST) && (posY_q == Y_LAST);
    assign divStart    = ((state_q == DIV_X) || (state_q == DIV_Y)) && !divPending_q && !divBusy;
    assign divDividend = (state_q == DIV_Y) ? sumY_q : sumX_q;
    assign cxQuot      = (divQuotient > X_LIMIT) ? X_LAST : divQuotient[XW-1:0];
    assign cyQuot      = (divQuotient > Y_LIMIT) ? Y_LAST : divQuotient[YW-1:0];

    seq_divider #(
        .N(SW),
        .D(CW)
    ) uDivider (
        .clk      (clk),
        .rst_n    (rst_n),
        .start    (divStart),
        .dividend (divDividend),
        .divisor  (cnt_q),
        .busy     (divBusy),
        .done     (divDone),
        .quotient (divQuotient)
    );

    // Frame controller: stream accounting, divider sequencing and result publication
    always_comb begin
        state_d      = state_q;
        posX_d       = posX_q;
        posY_d       = posY_q;
        sumX_d       = sumX_q;
        sumY_d       = sumY_q;
        cnt_d        = cnt_q;
        minX_d       = minX_q;
        maxX_d       = maxX_q;
        minY_d       = minY_q;
        maxY_d       = maxY_q;
        uLo_d        = uLo_q;
        uHi_d        = uHi_q;
        vLo_d        = vLo_q;
        vHi_d        = vHi_q;
        outValid_d   = outValid_q;
        outPixel_d   = outPixel_q;
        outLast_d    = outLast_q;
        divPending_d = divPending_q;
        cxInt_d      = cxInt_q;
        cyInt_d      = cyInt_q;
        resValid_d   = 1'b0;
        resFound_d   = resFound_q;
        resCount_d   = resCount_q;
        resCx_d      = resCx_q;
        resCy_d      = resCy_q;
        resMinX_d    = resMinX_q;
        resMaxX_d    = resMaxX_q;
        resMinY_d    = resMinY_q;
        resMaxY_d    = resMaxY_q;

        if (divStart) begin
            divPending_d = 1'b1;
        end else if (divDone) begin
            divPending_d = 1'b0;
        end

        if (pix.out_ready) begin
            outValid_d = 1'b0;
            outLast_d  = 1'b0;
        end

        case (state_q)
            IDLE: begin
                if (start) begin
                    uLo_d   = u_lo;
                    uHi_d   = u_hi;
                    vLo_d   = v_lo;
                    vHi_d   = v_hi;
                    posX_d  = '0;
                    posY_d  = '0;
                    sumX_d  = '0;
                    sumY_d  = '0;
                    cnt_d   = '0;
                    minX_d  = X_LAST;
                    minY_d  = Y_LAST;
                    maxX_d  = '0;
                    maxY_d  = '0;
                    state_d = STREAM;
                end
            end
            STREAM: begin
                if (accept) begin
                    outValid_d = 1'b1;
                    outPixel_d = isSkin ? '1 : '0;
                    outLast_d  = lastPix;
                    if (isSkin) begin
                        sumX_d = sumX_q + SW'(posX_q);
                        sumY_d = sumY_q + SW'(posY_q);
                        cnt_d  = cnt_q + CW'(1);
                        if (posX_q < minX_q) minX_d = posX_q;
                        if (posX_q > maxX_q) maxX_d = posX_q;
                        if (posY_q < minY_q) minY_d = posY_q;
                        if (posY_q > maxY_q) maxY_d = posY_q;
                    end
                    if (posX_q == X_LAST) begin
                        posX_d = '0;
                        posY_d = posY_q + YW'(1);
                    end else begin
                        posX_d = posX_q + XW'(1);
                    end
                    if (lastPix) begin
                        state_d = ((cnt_q != '0) || isSkin) ? DIV_X : REPORT;
                    end
                end
            end
            DIV_X: begin
                if (divDone) begin
                    cxInt_d = cxQuot;
                    state_d = DIV_Y;
                end
            end
            DIV_Y: begin
                if (divDone) begin
                    cyInt_d = cyQuot;
                    state_d = REPORT;
                end
            end
            REPORT: begin
                resValid_d = 1'b1;
                resFound_d = (cnt_q != '0);
                resCount_d = cnt_q;
                if (cnt_q != '0) begin
                    resCx_d   = cxInt_q;
                    resCy_d   = cyInt_q;
                    resMinX_d = minX_q;
                    resMaxX_d = maxX_q;
                    resMinY_d = minY_q;
                    resMaxY_d = maxY_q;
                end else begin
                    resCx_d   = '0;
                    resCy_d   = '0;
                    resMinX_d = '0;
                    resMaxX_d = '0;
                    resMinY_d = '0;
                    resMaxY_d = '0;
                end
                state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    // Controller, accumulator, mask output and result registers
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q      <= IDLE;
            posX_q       <= '0;
            posY_q       <= '0;
            sumX_q       <= '0;
            sumY_q       <= '0;
            cnt_q        <= '0;
            minX_q       <= '0;
            maxX_q       <= '0;
            minY_q       <= '0;
            maxY_q       <= '0;
            uLo_q        <= '0;
            uHi_q        <= '0;
            vLo_q        <= '0;
            vHi_q        <= '0;
            outValid_q   <= 1'b0;
            outPixel_q   <= '0;
            outLast_q    <= 1'b0;
            divPending_q <= 1'b0;
            cxInt_q      <= '0;
            cyInt_q      <= '0;
            resValid_q   <= 1'b0;
            resFound_q   <= 1'b0;
            resCount_q   <= '0;
            resCx_q      <= '0;
            resCy_q      <= '0;
            resMinX_q    <= '0;
            resMaxX_q    <= '0;
            resMinY_q    <= '0;
            resMaxY_q    <= '0;
        end else begin
            state_q      <= state_d;
            posX_q       <= posX_d;
            posY_q       <= posY_d;
            sumX_q       <= sumX_d;
            sumY_q       <= sumY_d;
            cnt_q        <= cnt_d;
            minX_q       <= minX_d;
            maxX_q       <= maxX_d;
            minY_q       <= minY_d;
            maxY_q       <= maxY_d;
            uLo_q        <= uLo_d;
            uHi_q        <= uHi_d;
            vLo_q        <= vLo_d;
            vHi_q        <= vHi_d;
            outValid_q   <= outValid_d;
            outPixel_q   <= outPixel_d;
            outLast_q    <= outLast_d;
            divPending_q <= divPending_d;
            cxInt_q      <= cxInt_d;
            cyInt_q      <= cyInt_d;
            resValid_q   <= resValid_d;
            resFound_q   <= resFound_d;
            resCount_q   <= resCount_d;
            resCx_q      <= resCx_d;
            resCy_q      <= resCy_d;
            resMinX_q    <= resMinX_d;
            resMaxX_q    <= resMaxX_d;
            resMinY_q    <= resMinY_d;
            resMaxY_q    <= resMaxY_d;
        end
    end

    assign pix.in_ready  = inReady;
    assign pix.out_valid = outValid_q;
    assign pix.out_pixel = outPixel_q;
    assign pix.out_last  = outLast_q;
    assign busy          = (state_q != IDLE);
    assign result_valid  = resValid_q;
    assign found         = resFound_q;
    assign count         = resCount_q;
    assign cx            = resCx_q;
    assign cy            = resCy_q;
    assign min_x         = resMinX_q;
    assign max_x         = resMaxX_q;
    assign min_y         = resMinY_q;
    assign max_y         = resMaxY_q;

endmodule

// File: tb/tb_skin_mask_frame.sv
// Directed bench for a 4x4 skin_mask_frame: mask stream, backpressure, results and abort.
module tb_skin_mask_frame;
    import skin_mask_pkg::*;

    localparam int W    = 4;
    localparam int H    = 4;
    localparam int CD   = 8;
    localparam int NPIX = W * H;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       start = 1'b0;
    logic [7:0] uLo, uHi, vLo, vHi;
    logic       busy, resultValid, found;
    logic [4:0] count;
    logic [1:0] cx, cy, minX, maxX, minY, maxY;

    skin_mask_frame_if #(.COLOR_DEPTH(CD)) pix();

    skin_mask_frame #(
        .WIDTH(W),
        .HEIGHT(H),
        .COLOR_DEPTH(CD)
    ) dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .start        (start),
        .u_lo         (uLo),
        .u_hi         (uHi),
        .v_lo         (vLo),
        .v_hi         (vHi),
        .pix          (pix),
        .busy         (busy),
        .result_valid (resultValid),
        .found        (found),
        .count        (count),
        .cx           (cx),
        .cy           (cy),
        .min_x        (minX),
        .max_x        (maxX),
        .min_y        (minY),
        .max_y        (maxY)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    logic [7:0] rTab[NPIX];
    logic [7:0] gTab[NPIX];
    logic [7:0] bTab[NPIX];
    logic       expMask[NPIX];

    int expFound, expCount, expCx, expCy, expMinX, expMaxX, expMinY, expMaxY;
    int capFound, capCount, capCx, capCy, capMinX, capMaxX, capMinY, capMaxY;
    int resPulses, resCycle, lastAccCycle, drained;

    // Single comparison point: counts every check and reports any mismatch
    task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
        checks++;
        if (observed !== expected) begin
            errors++;
            $display("[TB] FAIL %s observed=%0d expected=%0d", tag, observed, expected);
        end
    endtask

    task automatic clearFrame();
        for (int i = 0; i < NPIX; i++) begin
            rTab[i] = 8'd0;
            gTab[i] = 8'd0;
            bTab[i] = 8'd0;
            expMask[i] = 1'b0;
        end
    endtask

    task automatic setPixel(input int idx, input int r, input int g, input int b, input logic skin);
        rTab[idx] = 8'(r);
        gTab[idx] = 8'(g);
        bTab[idx] = 8'(b);
        expMask[idx] = skin;
    endtask

    task automatic setExpected(input int f, input int c, input int x, input int y,
                               input int x0, input int y0, input int x1, input int y1);
        expFound = f; expCount = c; expCx = x; expCy = y;
        expMinX = x0; expMinY = y0; expMaxX = x1; expMaxY = y1;
    endtask

    // Runs one frame; stalls the sink for stallLen cycles once stallAt pixels are in,
    // and returns early once abortAfter pixels have been accepted
    task automatic applyStimulus(input int stallAt, input int stallLen, input int abortAfter);
        int acc, cyc, stallLeft;
        acc = 0; cyc = 0; stallLeft = stallLen;
        drained = 0; resPulses = 0; resCycle = -1; lastAccCycle = -1;
        @(negedge clk);
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        while (1) begin
            if (abortAfter >= 0 && acc >= abortAfter) break;
            if (drained >= NPIX && resPulses > 0 && cyc > resCycle + 3) break;
            if (cyc >= 200) break;
            pix.in_valid = (acc < NPIX);
            if (acc < NPIX) begin
                pix.in_r = rTab[acc];
                pix.in_g = gTab[acc];
                pix.in_b = bTab[acc];
            end
            pix.out_ready = 1'b1;
            if (stallAt >= 0 && acc >= stallAt && stallLeft > 0) begin
                pix.out_ready = 1'b0;
                stallLeft--;
            end
            #1;
            if (cyc == 0) checkOutput("busyInFrame", busy, 1);
            if (resultValid) begin
                resPulses++;
                resCycle = cyc;
                capFound = found; capCount = count; capCx = cx; capCy = cy;
                capMinX = minX; capMaxX = maxX; capMinY = minY; capMaxY = maxY;
            end
            if (pix.out_valid && !pix.out_ready) checkOutput("inReadyHeld", pix.in_ready, 0);
            if (pix.out_valid && pix.out_ready) begin
                if (drained < NPIX) begin
                    checkOutput($sformatf("mask%0d", drained), pix.out_pixel, expMask[drained] ? 255 : 0);
                    checkOutput($sformatf("last%0d", drained), pix.out_last, (drained == NPIX - 1) ? 1 : 0);
                end
                drained++;
            end
            if (pix.in_valid && pix.in_ready) begin
                acc++;
                if (acc == NPIX) lastAccCycle = cyc;
            end
            cyc++;
            @(negedge clk);
        end
    endtask

    task automatic checkResults(input string tag);
        checkOutput({tag, "_drained"}, drained, NPIX);
        checkOutput({tag, "_pulses"}, resPulses, 1);
        checkOutput({tag, "_found"}, capFound, expFound);
        checkOutput({tag, "_count"}, capCount, expCount);
        checkOutput({tag, "_cx"}, capCx, expCx);
        checkOutput({tag, "_cy"}, capCy, expCy);
        checkOutput({tag, "_bbox"}, {capMinX[7:0], capMinY[7:0], capMaxX[7:0], capMaxY[7:0]},
                    {expMinX[7:0], expMinY[7:0], expMaxX[7:0], expMaxY[7:0]});
    endtask

    initial begin
        #500000;
        $display("[TB] FAIL watchdog expired at time %0t", $time);
        $fatal(1, "[TB] watchdog");
    end

    initial begin
        int seen;
        uLo = 8'(U_LO_DEF); uHi = 8'(U_HI_DEF);
        vLo = 8'(V_LO_DEF); vHi = 8'(V_HI_DEF);
        pix.in_valid = 1'b0; pix.in_r = '0; pix.in_g = '0; pix.in_b = '0;
        pix.out_ready = 1'b1;
        repeat (3) @(negedge clk);
        #1;
        checkOutput("rstBusy", busy, 0);
        checkOutput("rstInReady", pix.in_ready, 0);
        checkOutput("rstOutValid", pix.out_valid, 0);
        checkOutput("rstResults", {resultValid, found, count, cx, cy, minX, maxX, minY, maxY}, 0);
        @(negedge clk);
        rst_n = 1'b1;

        // Pixels offered while idle must be left alone
        pix.in_valid = 1'b1; pix.in_r = 8'd100; pix.in_g = 8'd50; pix.in_b = 8'd50;
        for (int i = 0; i < 2; i++) begin
            @(negedge clk);
            #1;
            checkOutput("idleInReady", pix.in_ready, 0);
        end
        pix.in_valid = 1'b0;

        $display("[TB] frame A: single skin pixel at (2,1)");
        clearFrame();
        setPixel(6, 100, 50, 50, 1'b1);
        setExpected(1, 1, 2, 1, 2, 1, 2, 1);
        applyStimulus(-1, 0, -1);
        checkResults("A");

        $display("[TB] frame B: corners (0,0) and (3,3)");
        clearFrame();
        setPixel(0, 100, 50, 50, 1'b1);
        setPixel(15, 100, 50, 50, 1'b1);
        setExpected(1, 2, 1, 1, 0, 0, 3, 3);
        applyStimulus(-1, 0, -1);
        checkResults("B");

        $display("[TB] frame C: U window boundaries");
        clearFrame();
        setPixel(0, 26, 0, 0, 1'b0);
        setPixel(1, 27, 0, 0, 1'b1);
        setPixel(2, 73, 0, 0, 1'b1);
        setPixel(3, 74, 0, 0, 1'b0);
        setExpected(1, 2, 1, 0, 1, 0, 2, 0);
        applyStimulus(-1, 0, -1);
        checkResults("C");

        $display("[TB] frame D: V lower bound at 10");
        vLo = 8'd10;
        clearFrame();
        setPixel(0, 60, 0, 5, 1'b0);
        setPixel(1, 60, 0, 10, 1'b1);
        setExpected(1, 1, 1, 0, 1, 0, 1, 0);
        applyStimulus(-1, 0, -1);
        checkResults("D");
        vLo = 8'(V_LO_DEF);

        $display("[TB] frame E: all black");
        clearFrame();
        setExpected(0, 0, 0, 0, 0, 0, 0, 0);
        applyStimulus(-1, 0, -1);
        checkResults("E");
        checkOutput("E_latency", ((resCycle - lastAccCycle) <= 2) ? 1 : 0, 1);

        $display("[TB] frame F: sink stalled 3 cycles mid-frame");
        clearFrame();
        setPixel(6, 100, 50, 50, 1'b1);
        setExpected(1, 1, 2, 1, 2, 1, 2, 1);
        applyStimulus(5, 3, -1);
        checkResults("F");

        $display("[TB] frame G: reset after 7 pixels, then a full frame");
        clearFrame();
        setPixel(0, 100, 50, 50, 1'b1);
        setPixel(15, 100, 50, 50, 1'b1);
        applyStimulus(-1, 0, 7);
        rst_n = 1'b0;
        #1;
        checkOutput("abortBusy", busy, 0);
        checkOutput("abortStream", {pix.in_ready, pix.out_valid, pix.out_pixel, pix.out_last}, 0);
        checkOutput("abortResults", {resultValid, found, count, cx, cy, minX, maxX, minY, maxY}, 0);
        pix.in_valid = 1'b0;
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        seen = 0;
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            #1;
            if (resultValid) seen++;
        end
        checkOutput("abortNoResult", seen, 0);
        checkOutput("abortIdle", busy, 0);
        setExpected(1, 2, 1, 1, 0, 0, 3, 3);
        applyStimulus(-1, 0, -1);
        checkResults("G");

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/skin_mask_frame.md
Name: skin_mask_frame

Overview:
- Parametrised successor to the fixed 256x256 skin-mask reader.
- Accepts one raster-order RGB frame over a valid/ready stream and classifies each pixel as skin by programmable chroma thresholds. Emits a 0/255 mask stream with backpressure.
- At end of frame, computes the mask bounding box, pixel count and integer centroid using a shared sequential divider.
- Sits between the camera/pixel source and the downstream smoothing/overlay stages. Needs no frame buffer.

Parameters:
- WIDTH, 256, pixels per line (>=2).
- HEIGHT, 256, lines per frame (>=2).
- COLOR_DEPTH, 8, bits per colour channel.
- Derived constants: XW=clog2(WIDTH), YW=clog2(HEIGHT), CW=clog2(WIDTH*HEIGHT+1), SW=max(XW,YW)+CW.

Ports:
- clk  in  1  rising-edge clock
- rst_n  in  1  asynchronous active-low reset
- start  in  1  pulse; begins a frame when idle; ignored otherwise
- u_lo, u_hi  in  COLOR_DEPTH each  U window; skin when u_lo < U < u_hi
- v_lo, v_hi  in  COLOR_DEPTH each  V window; skin when v_lo <= V <= v_hi
- in_valid  in  1  pixel valid
- in_ready  out  1  pixel accepted when in_valid && in_ready
- in_r, in_g, in_b  in  COLOR_DEPTH each  pixel colour
- out_valid  out  1  mask pixel valid
- out_ready  in  1  downstream ready
- out_pixel  out  COLOR_DEPTH  all ones if skin, else 0
- out_last  out  1  high with the final pixel of the frame
- busy  out  1  high in any state other than IDLE
- result_valid  out  1  one-cycle pulse; result ports updated
- found  out  1  at least one skin pixel in the last frame
- count  out  CW  skin pixel count
- cx  out  XW  centroid x
- cy  out  YW  centroid y
- min_x, max_x  out  XW each  bounding box x extent
- min_y, max_y  out  YW each  bounding box y extent

Behaviour:
- Reset: all outputs and internal registers are 0, and the state is IDLE. Reset asserted mid-frame or mid-divide aborts the operation; no result_valid is issued.
- States:
  - IDLE: on start, latch the four thresholds, clear posx/posy, accumulators and count, set min_x=WIDTH-1, min_y=HEIGHT-1, max_x=max_y=0, then go to STREAM.
  - STREAM: in_ready = !out_valid || out_ready.
  - On each accepted pixel:
    - U = R>G ? R-G : 0; V = B>G ? B-G : 0 (saturating).
    - Register out_pixel, out_valid=1 and out_last (posx==WIDTH-1 && posy==HEIGHT-1) on the next edge; latency is 1 cycle.
    - If skin: sum_x += posx, sum_y += posy, count += 1, and update min/max.
    - Advance posx; when posx wraps from WIDTH-1 to 0, increment posy.
  - out_valid clears when out_ready is high and no new pixel is accepted in the same cycle.
  - A simultaneous accept and drain must pass the pixel through with no bubble.
  - When the last pixel is accepted: go to DIV_X if count (including this pixel) > 0, else to REPORT with found=0.
  - DIV_X: start the divider with sum_x / count and wait for done. cx = floor quotient. Then go to DIV_Y.
  - DIV_Y: same with sum_y; cy = quotient. Then go to REPORT.
  - REPORT: update all result ports from internal registers and pulse result_valid for 1 cycle, then go to IDLE.
    - With found=0: cx, cy, count and bbox are all 0.
  - Result ports hold their values until the next REPORT.
- in_ready is 0 outside STREAM. Pixels offered in IDLE are not consumed.
- The final mask pixel may still be held in out_valid while DIV/REPORT run; it drains independently.
- start is ignored while busy=1. Thresholds changed mid-frame have no effect.
- Divider latency: SW+1 cycles per division.
- Worst-case frame end to result_valid: 2*(SW+2)+1 cycles.

Decomposition:
- Package skin_mask_pkg holds:
  - the state enum (IDLE, STREAM, DIV_X, DIV_Y, REPORT);
  - clog2-derived width functions;
  - default threshold constants U_LO_DEF=26, U_HI_DEF=74, V_LO_DEF=0, V_HI_DEF=255.
- Sub-module seq_divider:
  - Parameters N (dividend width) and D (divisor width).
  - Restoring division, one quotient bit per cycle.
  - Ports: clk, rst_n, start, dividend, divisor, busy, done (1-cycle pulse), quotient.
  - Divisor never 0 by construction.

Test Plan:
- WIDTH=HEIGHT=4, default thresholds; one pixel (100,50,50) at (2,1), all others (0,0,0). Required: out_pixel=255 only at index 6, out_last on index 15, then result_valid with found=1, count=1, cx=2, cy=1, bbox=(2,1)-(2,1).
- Skin pixels at (0,0) and (3,3). Required: count=2, cx=1, cy=1 (floor of 1.5), bbox=(0,0)-(3,3).
- Boundary U values 26, 27, 73, 74 (G=0, B=0). Required: masks 0, 255, 255, 0. With v_lo=10 and pixel (60,0,5): mask 0.
- All-black frame. Required: found=0, count=0, cx=cy=0, and result_valid within 2 cycles of the last accept.
- out_ready held low for 3 cycles mid-frame with in_valid continuously high. Required: in_ready low while the output is held, no pixel lost or duplicated, 16 outputs in order.
- rst_n pulsed low after 7 pixels. Required: all outputs 0 immediately and no result_valid. A fresh start with a full frame then produces the correct result.
